// File: rtl/cab_input_pkg.sv
// Shared types and default bit positions for the cabinet input controller.
// The auto-play sequencer is built only when CAB_AUTO_PLAY_EN is defined.
package cab_input_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCoin,
    StGap1,
    StStart,
    StGap2,
    StPlay
  } seq_state_e;

  // Centipede playerinput_i map
  localparam int unsigned CentipedeCoinIdx  = 7;
  localparam int unsigned CentipedeStartIdx = 1;
  localparam int unsigned CentipedeFireIdx  = 0;

endpackage

// File: rtl/cab_debounce.sv
// One-bit 2-flop synchroniser followed by a saturating-count debouncer.
// Input is active-low; the debounced value resets to released (1).
module cab_debounce #(
  parameter int unsigned DB_CYCLES = 16'd60000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic debounced
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            deb_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign debounced = deb_q;

endmodule

// File: rtl/cab_input_ctrl.sv
// Cabinet input conditioning, game-reset stretcher and optional auto-play sequencer.
// Define CAB_AUTO_PLAY_EN to build the coin/start/fire sequencer.
module cab_input_ctrl
  import cab_input_pkg::*;
#(
  parameter int unsigned N_IN        = 10,
  parameter int unsigned DB_CYCLES   = 16'd60000,
  parameter int unsigned RST_CYCLES  = 24'd1200000,
  parameter int unsigned AUTO_PERIOD = 32'd120000000,
  parameter int unsigned AUTO_PULSE  = 24'd1200000,
  parameter int unsigned COIN_IDX    = CentipedeCoinIdx,
  parameter int unsigned START_IDX   = CentipedeStartIdx,
  parameter int unsigned FIRE_IDX    = CentipedeFireIdx
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_IN-1:0] btn_n_i,
  input  logic            reset_btn_i,
  input  logic            auto_en_i,
  output logic [N_IN-1:0] player_n_o,
  output logic            game_reset_o,
  output logic            auto_busy_o
);

  localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
  localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);

  // Top bit carries the inverted reset button so it shares the active-low path.
  logic [N_IN:0] raw_all;
  logic [N_IN:0] deb_all;

  assign raw_all = {~reset_btn_i, btn_n_i};

  for (genvar i = 0; i <= N_IN; i++) begin : g_db
    cab_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .raw      (raw_all[i]),
      .debounced(deb_all[i])
    );
  end

  logic            rst_btn_pressed;
  logic            game_reset_q;
  logic [RstW-1:0] rst_cnt_q;

  assign rst_btn_pressed = ~deb_all[N_IN];

  // Leaving reset_n low counts as a release, so the stretch also runs at power-up.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      game_reset_q <= 1'b1;
      rst_cnt_q    <= '0;
    end else if (rst_btn_pressed) begin
      game_reset_q <= 1'b1;
      rst_cnt_q    <= '0;
    end else if (game_reset_q) begin
      if (rst_cnt_q == RstLast) begin
        game_reset_q <= 1'b0;
        rst_cnt_q    <= '0;
      end else begin
        rst_cnt_q <= rst_cnt_q + RstW'(1);
      end
    end
  end

  assign game_reset_o = game_reset_q;

  logic [N_IN-1:0] inject;

`ifdef CAB_AUTO_PLAY_EN
  localparam logic [31:0] PeriodLast = 32'(AUTO_PERIOD - 1);
  localparam logic [31:0] PulseLast  = 32'(AUTO_PULSE - 1);
  localparam logic [N_IN-1:0] CoinMask  = N_IN'(1) << COIN_IDX;
  localparam logic [N_IN-1:0] StartMask = N_IN'(1) << START_IDX;
  localparam logic [N_IN-1:0] FireMask  = N_IN'(1) << FIRE_IDX;

  seq_state_e  state_q;
  logic [31:0] seq_cnt_q;
  logic        fire_q;
  logic        busy_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      seq_cnt_q <= '0;
      fire_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      busy_q <= (state_q != StIdle);
      if (!auto_en_i || game_reset_q) begin
        state_q   <= StIdle;
        seq_cnt_q <= '0;
        fire_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q   <= StWait;
            seq_cnt_q <= '0;
          end
          StWait: begin
            if (seq_cnt_q == PeriodLast) begin
              state_q   <= StCoin;
              seq_cnt_q <= '0;
            end else begin
              seq_cnt_q <= seq_cnt_q + 32'd1;
            end
          end
          StCoin, StGap1, StStart, StGap2: begin
            if (seq_cnt_q == PulseLast) begin
              seq_cnt_q <= '0;
              unique case (state_q)
                StCoin:  state_q <= StGap1;
                StGap1:  state_q <= StStart;
                StStart: state_q <= StGap2;
                default: begin
                  state_q <= StPlay;
                  fire_q  <= 1'b1;
                end
              endcase
            end else begin
              seq_cnt_q <= seq_cnt_q + 32'd1;
            end
          end
          StPlay: begin
            if (seq_cnt_q == PulseLast) begin
              fire_q    <= ~fire_q;
              seq_cnt_q <= '0;
            end else begin
              seq_cnt_q <= seq_cnt_q + 32'd1;
            end
          end
          default: begin
            state_q   <= StIdle;
            seq_cnt_q <= '0;
            fire_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    inject = '0;
    if (state_q == StCoin)            inject = inject | CoinMask;
    if (state_q == StStart)           inject = inject | StartMask;
    if (state_q == StPlay && fire_q)  inject = inject | FireMask;
  end

  assign auto_busy_o = busy_q;
`else
  localparam int unsigned unused_auto_cfg =
      AUTO_PERIOD + AUTO_PULSE + COIN_IDX + START_IDX + FIRE_IDX;
  logic unused_auto_en;

  assign unused_auto_en = auto_en_i;
  assign inject         = '0;
  assign auto_busy_o    = 1'b0;
`endif

  logic [N_IN-1:0] player_q;

  // Injection can only pull a bit low; a real press always gets through.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      player_q <= '1;
    end else begin
      player_q <= deb_all[N_IN-1:0] & ~inject;
    end
  end

  assign player_n_o = player_q;

endmodule

// File: doc/cab_input_ctrl.md
# cab_input_ctrl

Parametrised cabinet-input and game-reset controller for arcade cores on the LX45 board. Synchronises and debounces N active-low player inputs, stretches the game reset from the board button, and optionally injects an automatic coin/start/fire sequence for attract-mode bring-up. It replaces the fixed player-input constant and button-reset logic at the board top; its outputs drive the core's `playerinput_i` and `reset` directly.

## Interface
- N_IN, 10: number of player inputs (active-low, bit order as the core's `playerinput_i`)
- DB_CYCLES, 16'd60000: debounce qualification length in clk cycles, ≥1
- RST_CYCLES, 24'd1200000: game-reset stretch after release, ≥1
- AUTO_PERIOD, 32'd120000000: idle cycles before each auto coin
- AUTO_PULSE, 24'd1200000: auto pulse/gap length, ≥1
- COIN_IDX, 7 / START_IDX, 1 / FIRE_IDX, 0: bit positions driven by the auto sequencer
- clk  in  1  core clock (clk12m domain)
- reset_n  in  1  synchronous, active-low reset
- btn_n_i  in  N_IN  raw asynchronous player inputs, 0 = pressed
- reset_btn_i  in  1  raw asynchronous board reset button, 1 = pressed
- auto_en_i  in  1  enable for the auto sequencer (level)
- player_n_o  out  N_IN  conditioned inputs, 0 = pressed
- game_reset_o  out  1  active-high reset to the game core
- auto_busy_o  out  1  sequencer outside IDLE

## Operation
- Each input: 2-flop synchroniser, then debouncer. Counter increments while synced value ≠ debounced value, clears when equal; when count reaches DB_CYCLES-1 and still different, debounced value takes synced value and counter clears. Counter width $clog2(DB_CYCLES+1); never wraps.
- Reset button: same synchroniser + debouncer path (polarity inverted). game_reset_o = 1 while debounced button pressed; on release, stays 1 for RST_CYCLES more cycles, then 0. Re-press during stretch reloads and holds.
- Auto sequencer states: IDLE → WAIT (auto_en_i=1) → COIN (after AUTO_PERIOD) → GAP1 → START → GAP2 → PLAY; each of COIN, GAP1, START, GAP2 lasts AUTO_PULSE cycles. In PLAY, fire bit toggles every AUTO_PULSE cycles, starting pressed. auto_en_i=0 in any state → IDLE next cycle, all injections released. game_reset_o=1 forces IDLE.
- Output: player_n_o[i] = debounced[i] AND NOT inject[i], registered. Injection only pulls low; real presses always pass.
- Simultaneous real and injected press on same bit: output low; release occurs only when both released.

## Timing
- Reset values (reset_n=0 at edge): player_n_o = all 1s, game_reset_o = 1, auto_busy_o = 0, all counters 0, debounced state = released, sequencer IDLE.
- After reset_n rises, game_reset_o stays 1 for exactly RST_CYCLES cycles (treated as a release event).
- Input press to player_n_o: exactly DB_CYCLES+3 clk edges if stable (2 sync + DB_CYCLES qualify + 1 output register). Glitch shorter than DB_CYCLES cycles: no output change.
- auto_busy_o registered; asserts the cycle after WAIT entry, deasserts the cycle after IDLE entry.
- Injection reaches player_n_o one cycle after the sequencer state change.

## Configuration
- CAB_AUTO_PLAY_EN defined: sequencer compiled in as above.
- Not defined: no sequencer logic; auto_en_i ignored, auto_busy_o tied 0, player_n_o is the registered debounced inputs only. AUTO_* and *_IDX parameters remain declared but unused.

## Structure
- Package cab_input_pkg: sequencer state enum (IDLE, WAIT, COIN, GAP1, START, GAP2, PLAY), default index constants for the Centipede input map.
- Sub-module cab_debounce (synchroniser + counter, one bit, parameter DB_CYCLES, reset polarity of parent), instantiated N_IN+1 times via generate.
- Top of module: reset stretcher, sequencer, output register.

## Test plan
- Reset: hold reset_n=0 5 cycles with btn_n_i=0 → player_n_o=all 1s, game_reset_o=1; release with RST_CYCLES=8 → game_reset_o falls after exactly 8 cycles.
- Debounce (DB_CYCLES=4): btn_n_i[0] low 3 cycles then high → no change; low 10 cycles → player_n_o[0] falls exactly 7 edges after input change.
- Reset button (DB_CYCLES=4, RST_CYCLES=8): press 20 cycles → game_reset_o=1 from cycle 6; release → falls 8 cycles after debounced release; re-press mid-stretch → stretch restarts.
- Auto sequence (AUTO_PERIOD=10, AUTO_PULSE=3): auto_en_i=1 → bit 7 low 3 cycles after 10, 3 gap, bit 1 low 3, 3 gap, bit 0 toggles every 3 cycles; auto_en_i=0 in PLAY → all bits high within 2 cycles, auto_busy_o=0.
- Overlap: real btn_n_i[1] held during auto START → player_n_o[1] stays low after START ends until real release + DB_CYCLES+3.
- Macro off: auto_en_i=1 for 100 cycles → player_n_o unchanged all 1s, auto_busy_o=0.
